training_data_feeder: RTL and testbench

//   Sample source upstream of the neuron training controller: holds a training set of
//   (x1, x2, t) samples and serves one sample per request via requestFlag/dataReady.

---
 rtl/neuron_pkg.sv | 29 ++
 rtl/sample_ram.sv | 23 ++
 rtl/training_data_feeder.sv | 97 +++++++++
 tb/tb_training_data_feeder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron training slice: sample format,
// training-set geometry and the feeder state encoding.
package neuron_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_READ,
    FEED_VALID
  } feed_state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] t;
  } sample_t;

  // Out-of-range epoch lengths fall back to the whole RAM.
  function automatic logic [ADDR_W:0] eff_count(input logic [ADDR_W:0] sample_count);
    if (sample_count == '0 || sample_count > DEPTH_CNT) return DEPTH_CNT;
    return sample_count;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Training-set storage: one write port, one synchronous read port,
// one-cycle read latency, write-first on a same-address collision.
module sample_ram
  import neuron_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  sample_t           wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output sample_t           rdata
);

  sample_t mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros; contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/training_data_feeder.sv
// Serves one training sample per controller request, marks the last sample of
// each epoch with flagEOF and wraps back to slot 0.
module training_data_feeder
  import neuron_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic signed [DATA_W-1:0] wrX1,
  input  logic signed [DATA_W-1:0] wrX2,
  input  logic signed [DATA_W-1:0] wrT,
  input  logic [ADDR_W:0]          sampleCount,
  input  logic                     rewind,
  input  logic                     requestFlag,
  output logic                     dataReady,
  output logic signed [DATA_W-1:0] x1,
  output logic signed [DATA_W-1:0] x2,
  output logic signed [DATA_W-1:0] t,
  output logic                     flagEOF,
  output logic                     busy
);

  feed_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   eff_q;
  logic              rewind_pend;
  sample_t           rd_data;
  sample_t           wr_data;
  logic              start_read;
  logic              wr_accept;
  logic              is_last;

  assign busy       = (state != FEED_IDLE);
  assign wr_accept  = wrEn && !busy;
  assign start_read = (state == FEED_IDLE) && !rewind && requestFlag;
  assign is_last    = ({1'b0, ptr} == eff_q - 1'b1);
  assign wr_data    = '{x1: wrX1, x2: wrX2, t: wrT};

  sample_ram u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wrAddr),
    .wdata (wr_data),
    .re    (start_read),
    .raddr (ptr),
    .rdata (rd_data)
  );

  // NOTE: every state register is assigned with <= so all of them update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FEED_IDLE;
      ptr         <= '0;
      eff_q       <= DEPTH_CNT;
      rewind_pend <= 1'b0;
      dataReady   <= 1'b0;
      flagEOF     <= 1'b0;
      x1          <= '0;
      x2          <= '0;
      t           <= '0;
    end else begin
      dataReady <= 1'b0;
      case (state)
        FEED_IDLE: begin
          eff_q       <= eff_count(sampleCount);
          rewind_pend <= 1'b0;
          if (rewind) begin
            ptr     <= '0;
            flagEOF <= 1'b0;
          end else if (requestFlag) begin
            state <= FEED_READ;
          end
        end
        FEED_READ: begin
          x1        <= rd_data.x1;
          x2        <= rd_data.x2;
          t         <= rd_data.t;
          dataReady <= 1'b1;
          flagEOF   <= is_last;
          ptr       <= is_last ? '0 : ptr + 1'b1;
          if (rewind) rewind_pend <= 1'b1;
          state <= FEED_VALID;
        end
        FEED_VALID: begin
          // A rewind seen mid-delivery only takes effect once the sample is out.
          if (rewind || rewind_pend) ptr <= '0;
          rewind_pend <= 1'b0;
          state       <= FEED_IDLE;
        end
        default: state <= FEED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_training_data_feeder.sv
// Directed self-checking bench for training_data_feeder.
module tb_training_data_feeder;

  logic              clk = 1'b0;
  logic              rst;
  logic              wrEn;
  logic [3:0]        wrAddr;
  logic signed [7:0] wrX1, wrX2, wrT;
  logic [4:0]        sampleCount;
  logic              rewind;
  logic              requestFlag;
  logic              dataReady;
  logic signed [7:0] x1, x2, t;
  logic              flagEOF;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int mx1 [16];
  int mx2 [16];
  int mt  [16];

  training_data_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .wrX1        (wrX1),
    .wrX2        (wrX2),
    .wrT         (wrT),
    .sampleCount (sampleCount),
    .rewind      (rewind),
    .requestFlag (requestFlag),
    .dataReady   (dataReady),
    .x1          (x1),
    .x2          (x2),
    .t           (t),
    .flagEOF     (flagEOF),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a write and record it in the reference model; no clock edge here.
  task automatic set_wr(input int addr, input int a, input int b, input int c);
    wrEn   = 1'b1;
    wrAddr = 4'(addr);
    wrX1   = 8'(a);
    wrX2   = 8'(b);
    wrT    = 8'(c);
    mx1[addr] = a;
    mx2[addr] = b;
    mt[addr]  = c;
  endtask

  task automatic load(input int addr, input int a, input int b, input int c);
    set_wr(addr, a, b, c);
    tick();
    wrEn = 1'b0;
  endtask

  task automatic pulse_rewind();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
  endtask

  // Controller-style request: hold requestFlag until dataReady, then drop it.
  // wrEn/rewind set by the caller are cleared after the first edge.
  task automatic req(input string tag, input int idx, input int eeof, input int lat);
    int n;
    n = 0;
    requestFlag = 1'b1;
    do begin
      tick();
      n++;
      wrEn   = 1'b0;
      rewind = 1'b0;
    end while (!dataReady && n < 8);
    requestFlag = 1'b0;
    check({tag, "_rdy"}, int'(dataReady), 1);
    check({tag, "_lat"}, n, lat);
    check({tag, "_x1"}, x1, mx1[idx]);
    check({tag, "_x2"}, x2, mx2[idx]);
    check({tag, "_t"}, t, mt[idx]);
    check({tag, "_eof"}, int'(flagEOF), eeof);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b0; wrEn = 1'b0; wrAddr = '0; wrX1 = '0; wrX2 = '0; wrT = '0;
    sampleCount = 5'd4; rewind = 1'b0; requestFlag = 1'b0;
    repeat (3) tick();
    check("rst_rdy", int'(dataReady), 0);
    check("rst_x1", x1, 0);
    check("rst_x2", x2, 0);
    check("rst_t", t, 0);
    check("rst_eof", int'(flagEOF), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick();

    load(0, 1, 2, 1);
    load(1, -3, 4, -1);
    load(2, 5, -6, 1);
    load(3, 7, 7, -1);

    // Epoch of 4, with latency and hold checks on the first delivery.
    requestFlag = 1'b1;
    tick(); check("lat_c1_rdy", int'(dataReady), 0); check("lat_c1_busy", int'(busy), 1);
    tick(); check("lat_c2_rdy", int'(dataReady), 1); check("lat_c2_x1", x1, 1);
    requestFlag = 1'b0;
    tick(); check("lat_c3_rdy", int'(dataReady), 0); check("hold_x1", x1, 1);
    check("hold_x2", x2, 2); check("hold_t", t, 1);
    tick(); check("hold2_x2", x2, 2);
    req("s1", 1, 0, 2);
    req("s2", 2, 0, 2);
    req("s3", 3, 1, 2);
    check("eof_hold", int'(flagEOF), 1);
    req("wrap", 0, 0, 2);

    // Rewind after further deliveries clears flagEOF and restarts at slot 0.
    req("r1", 1, 0, 2);
    req("r2", 2, 0, 2);
    req("r3", 3, 1, 2);
    pulse_rewind();
    check("rew_eof_clr", int'(flagEOF), 0);
    req("rew_s0", 0, 0, 2);

    // Rewind and request together: rewind wins, slot 0 read one cycle later.
    rewind = 1'b1;
    req("rew_req", 0, 0, 3);

    // Write during READ is dropped.
    requestFlag = 1'b1;
    tick(); check("wrbusy_busy", int'(busy), 1);
    wrEn = 1'b1; wrAddr = 4'd1; wrX1 = 8'sd99; wrX2 = 8'sd99; wrT = 8'sd99;
    tick(); check("wrbusy_rdy", int'(dataReady), 1); check("wrbusy_x1", x1, -3);
    wrEn = 1'b0; requestFlag = 1'b0;
    tick();
    pulse_rewind();
    req("wrb_s0", 0, 0, 2);
    req("wrb_s1", 1, 0, 2);

    // Single-sample epoch flags EOF every time.
    sampleCount = 5'd1;
    pulse_rewind();
    req("one_a", 0, 1, 2);
    req("one_b", 0, 1, 2);

    // sampleCount=0 means the full 16-slot epoch.
    for (int i = 4; i < 16; i++) load(i, 2 * i, -i, i);
    sampleCount = 5'd0;
    pulse_rewind();
    for (int i = 0; i < 16; i++) req($sformatf("full%0d", i), i, (i == 15) ? 1 : 0, 2);
    req("full_wrap", 0, 0, 2);

    // Reset while a read is in flight: no delivery, outputs cleared, ptr back to 0.
    sampleCount = 5'd4;
    pulse_rewind();
    req("pre_rst", 0, 0, 2);
    requestFlag = 1'b1;
    tick(); check("mid_busy", int'(busy), 1);
    rst = 1'b0; requestFlag = 1'b0;
    tick();
    check("mid_rdy", int'(dataReady), 0);
    check("mid_x1", x1, 0);
    check("mid_x2", x2, 0);
    check("mid_eof", int'(flagEOF), 0);
    check("mid_busy0", int'(busy), 0);
    rst = 1'b1;
    seen = 0;
    repeat (3) begin tick(); seen |= int'(dataReady); end
    check("mid_no_rdy", seen, 0);
    req("post_rst", 0, 0, 2);

    // Write and request in the same IDLE cycle: read returns the new data.
    set_wr(1, 11, 12, 13);
    req("wr_req", 1, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
